tl_ul_ram_responder: RTL and testbench



---
 rtl/tl_ul_ram_responder_if.sv | 43 ++++
 rtl/tl_ul_ram_responder.sv | 165 ++++++++++++++++
 tb/tb_tl_ul_ram_responder.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_ul_ram_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : tl_ul_ram_responder_if
// TileLink-UL A (request) and D (response) channel bundle.
// Revision  : 1.0
// ============================================================================
interface tl_ul_ram_responder_if;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [2:0]  a_size;
    logic [6:0]  a_source;
    logic [25:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [6:0]  d_source;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt,
        input  d_ready
    );
endinterface
`default_nettype wire

// File: rtl/tl_ul_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tl_ul_ram_responder
// TileLink-UL RAM responder: Get/PutFull/PutPartial with byte masks,
// denied answers for illegal beats, 3-entry registered D-channel queue.
// Revision : 1.0
// ============================================================================
module tl_ul_ram_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [25:0] BASE_ADDR   = 26'h0
) (
    input  wire logic            clock,
    input  wire logic            reset,
    tl_ul_ram_responder_if.slave tl
);
    localparam int unsigned c_AW       = $clog2(DEPTH_WORDS);
    localparam logic [26:0] c_END      = {1'b0, BASE_ADDR} + 27'(DEPTH_WORDS * 4);
    localparam logic [2:0]  c_OP_PUTF  = 3'd0;
    localparam logic [2:0]  c_OP_PUTP  = 3'd1;
    localparam logic [2:0]  c_OP_GET   = 3'd4;

    typedef struct packed {
        logic       is_get;
        logic [2:0] size;
        logic [6:0] source;
        logic       denied;
        logic       corrupt;
        logic       use_data;
    } meta_t;

    typedef struct packed {
        meta_t       meta;
        logic [31:0] data;
    } entry_t;

    function automatic logic [1:0] f_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic             w_fire;
    logic [25:0]      w_offset;
    logic             w_in_range;
    logic             w_aligned;
    logic             w_is_get;
    logic             w_is_put;
    logic             w_legal;
    logic             w_write;
    logic [c_AW-1:0]  w_index;
    meta_t            w_meta;
    logic             w_unused;

    assign w_fire     = tl.a_valid & tl.a_ready;
    assign w_offset   = tl.a_address - BASE_ADDR;
    assign w_in_range = ({1'b0, tl.a_address} >= {1'b0, BASE_ADDR}) && ({1'b0, tl.a_address} < c_END);
    assign w_is_get   = (tl.a_opcode == c_OP_GET);
    assign w_is_put   = (tl.a_opcode == c_OP_PUTF) || (tl.a_opcode == c_OP_PUTP);
    assign w_legal    = w_in_range & w_aligned & (tl.a_size <= 3'd2) & (w_is_get | w_is_put);
    assign w_write    = w_fire & w_legal & w_is_put & ~tl.a_corrupt;
    assign w_index    = w_offset[c_AW+1:2];
    assign w_unused   = ^{tl.a_param, w_offset[25:c_AW+2], w_offset[1:0]};

    always_comb begin
        w_aligned = 1'b0;
        case (tl.a_size)
            3'd0:    w_aligned = 1'b1;
            3'd1:    w_aligned = ~tl.a_address[0];
            3'd2:    w_aligned = ~|tl.a_address[1:0];
            default: w_aligned = 1'b0;
        endcase
    end

    // Illegal Gets are flagged corrupt as well as denied; illegal others only denied.
    always_comb begin
        w_meta          = '0;
        w_meta.is_get   = w_is_get;
        w_meta.size     = tl.a_size;
        w_meta.source   = tl.a_source;
        w_meta.denied   = ~w_legal;
        w_meta.corrupt  = ~w_legal & w_is_get;
        w_meta.use_data = w_legal & w_is_get;
    end

    // RAM contents survive reset; read data lands one cycle after A fire.
    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clock) begin
        if (w_fire) begin
            r_rdata <= r_mem[w_index];
        end
        if (w_write) begin
            for (int b = 0; b < 4; b++) begin
                if (tl.a_mask[b]) begin
                    r_mem[w_index][8*b +: 8] <= tl.a_data[8*b +: 8];
                end
            end
        end
    end

    logic  r_s1_valid;
    meta_t r_s1_meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_meta  <= '0;
        end else begin
            r_s1_valid <= w_fire;
            if (w_fire) begin
                r_s1_meta <= w_meta;
            end
        end
    end

    entry_t     r_fifo [3];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;
    logic       w_dvalid;
    entry_t     w_push_entry;
    entry_t     w_head;

    assign w_dvalid     = (r_count != 2'd0);
    assign w_push       = r_s1_valid;
    assign w_pop        = w_dvalid & tl.d_ready;
    assign w_push_entry = {r_s1_meta, r_s1_meta.use_data ? r_rdata : 32'h0};
    assign w_head       = r_fifo[r_rd_ptr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Depends only on registered occupancy, never on d_ready.
    assign tl.a_ready   = ({1'b0, r_count} + {2'b00, r_s1_valid}) < 3'd3;

    assign tl.d_valid   = w_dvalid;
    assign tl.d_opcode  = {2'b00, w_dvalid & w_head.meta.is_get};
    assign tl.d_param   = 2'b00;
    assign tl.d_size    = w_dvalid ? w_head.meta.size   : 3'd0;
    assign tl.d_source  = w_dvalid ? w_head.meta.source : 7'd0;
    assign tl.d_denied  = w_dvalid & w_head.meta.denied;
    assign tl.d_corrupt = w_dvalid & w_head.meta.corrupt;
    assign tl.d_data    = w_dvalid ? w_head.data : 32'h0;
endmodule
`default_nettype wire

// File: tb/tb_tl_ul_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_ul_ram_responder
// Scoreboard bench: stimulus pushes model responses, D monitor pops/compares.
// Revision : 1.0
// ============================================================================
module tb_tl_ul_ram_responder;
    localparam int          DEPTH = 64;
    localparam logic [25:0] BASE  = 26'h100;

    logic clock = 1'b0;
    logic reset;

    tl_ul_ram_responder_if tl();

    tl_ul_ram_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock (clock),
        .reset (reset),
        .tl    (tl)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [2:0]  size;
        logic [6:0]  source;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } rsp_t;

    typedef struct {
        rsp_t r;
        bit   check_data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem [DEPTH];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          accepted = 0;
    int          fire_cyc = 0;
    int          dfire_cyc[$];
    int          ready_mode = 1;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: response and memory effect straight from the request rules.
    function automatic exp_t model(input logic [2:0] op, input logic [2:0] size, input logic [6:0] src,
                                   input logic [25:0] addr, input logic [3:0] mask,
                                   input logic [31:0] data, input logic corrupt);
        exp_t   e;
        longint a     = longint'(addr);
        longint lo    = longint'(BASE);
        longint hi    = lo + DEPTH * 4;
        bit     legal = (a >= lo) && (a < hi) && (size <= 2) &&
                        ((a % (longint'(1) << size)) == 0) && (op == 0 || op == 1 || op == 4);
        int     idx   = int'((a - lo) / 4);
        e.r = '0;
        e.r.opcode = (op == 3'd4) ? 3'd1 : 3'd0;
        e.r.size = size;
        e.r.source = src;
        e.check_data = 1'b1;
        if (!legal) begin
            e.r.denied = 1'b1;
            e.r.corrupt = (op == 3'd4);
        end else if (op == 3'd4) begin
            e.r.data = mem[idx];
        end else begin
            e.check_data = 1'b0;
            if (!corrupt)
                for (int b = 0; b < 4; b++)
                    if (mask[b]) mem[idx][8*b +: 8] = data[8*b +: 8];
        end
        return e;
    endfunction

    task automatic send(input logic [2:0] op, input logic [2:0] size, input logic [6:0] src,
                        input logic [25:0] addr, input logic [3:0] mask,
                        input logic [31:0] data, input logic corrupt);
        int w = 0;
        tl.a_valid = 1'b1;  tl.a_opcode = op;  tl.a_param = 3'd0;  tl.a_size = size;
        tl.a_source = src;  tl.a_address = addr;  tl.a_mask = mask;
        tl.a_data = data;  tl.a_corrupt = corrupt;
        @(negedge clock);
        while (!tl.a_ready && w < 200) begin
            @(negedge clock);
            w++;
        end
        if (!tl.a_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL a_ready_timeout: a_ready=%0d required 1", tl.a_ready);
            tl.a_valid = 1'b0;
            return;
        end
        fire_cyc = cyc;
        exp_q.push_back(model(op, size, src, addr, mask, data, corrupt));
        accepted++;
        @(posedge clock);
        #1;
        tl.a_valid = 1'b0;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    initial begin
        tl.d_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            tl.d_ready = (ready_mode == 2) ? 1'($urandom_range(0, 3) != 0) : 1'(ready_mode == 1);
        end
    end

    // D-channel monitor: stability while stalled, in-order compare on each D fire.
    rsp_t act;
    rsp_t prev;
    rsp_t cmp;
    exp_t e;
    bit   prev_held = 1'b0;

    always @(negedge clock) begin
        if (reset && tl.d_valid) begin
            act = {tl.d_opcode, tl.d_param, tl.d_size, tl.d_source, tl.d_denied, tl.d_data, tl.d_corrupt};
            if (prev_held) begin
                n_cmp++;
                if (act !== prev) begin
                    n_err++;
                    $display("FAIL d_stable: got %h required %h", act, prev);
                end
            end
            if (tl.d_ready) begin
                dfire_cyc.push_back(cyc);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL d_unexpected: got %h required no response", act);
                end else begin
                    e = exp_q.pop_front();
                    cmp = act;
                    if (!e.check_data) cmp.data = e.r.data;
                    if (cmp !== e.r) begin
                        n_err++;
                        $display("FAIL d_response: got %h required %h", act, e.r);
                    end
                end
                prev_held = 1'b0;
            end else begin
                prev = act;
                prev_held = 1'b1;
            end
        end else begin
            prev_held = 1'b0;
        end
    end

    logic [2:0]  r_op, r_sz;
    logic [25:0] r_addr;
    int          w;
    int          first_fire;
    bit          bp_done;

    initial begin
        tl.a_valid = 1'b0;  tl.a_opcode = '0;  tl.a_param = '0;  tl.a_size = '0;
        tl.a_source = '0;  tl.a_address = '0;  tl.a_mask = '0;  tl.a_data = '0;  tl.a_corrupt = 1'b0;
        reset = 1'b0;
        #1;
        check("reset_a_ready", 64'(tl.a_ready), 64'd1);
        check("reset_d_outputs", 64'({tl.d_valid, tl.d_opcode, tl.d_param, tl.d_size, tl.d_source,
                                      tl.d_denied, tl.d_data, tl.d_corrupt}), 64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < DEPTH; i++)
            send(3'd0, 3'd2, 7'(i), BASE + 26'(4 * i), 4'hF, $urandom, 1'b0);

        send(3'd0, 3'd2, 7'd1, BASE + 26'h10, 4'hF, 32'hDEADBEEF, 1'b0);
        send(3'd4, 3'd2, 7'd5, BASE + 26'h10, 4'h0, 32'h0, 1'b0);
        send(3'd1, 3'd2, 7'd6, BASE + 26'h10, 4'h6, 32'h11223344, 1'b0);
        send(3'd4, 3'd2, 7'd7, BASE + 26'h10, 4'hF, 32'h0, 1'b0);
        send(3'd4, 3'd2, 7'd8, BASE + 26'(DEPTH * 4), 4'hF, 32'h0, 1'b0);
        send(3'd2, 3'd2, 7'd9, BASE + 26'h14, 4'hF, 32'h0, 1'b0);
        send(3'd0, 3'd2, 7'd10, BASE + 26'h12, 4'hF, 32'hCAFEF00D, 1'b0);
        send(3'd0, 3'd2, 7'd11, BASE + 26'h10, 4'hF, 32'h55555555, 1'b1);
        send(3'd4, 3'd1, 7'd12, BASE + 26'h11, 4'hF, 32'h0, 1'b0);
        send(3'd4, 3'd2, 7'd13, BASE + 26'h10, 4'hF, 32'h0, 1'b0);
        send(3'd4, 3'd2, 7'd14, BASE - 26'd4, 4'hF, 32'h0, 1'b0);
        send(3'd4, 3'd2, 7'd15, BASE + 26'(DEPTH * 4 - 4), 4'hF, 32'h0, 1'b0);

        // Latency: first D beat two cycles after the fire cycle.
        repeat (4) @(posedge clock);
        #1;
        send(3'd4, 3'd2, 7'd20, BASE + 26'h20, 4'hF, 32'h0, 1'b0);
        w = 0;
        do begin
            @(negedge clock);
            w++;
        end while (!tl.d_valid && w < 10);
        check("latency", 64'(cyc - fire_cyc), 64'd2);

        // Back-pressure.
        ready_mode = 0;
        repeat (2) @(posedge clock);
        #1;
        accepted = 0;
        bp_done = 1'b0;
        fork
            begin
                for (int s = 0; s < 5; s++)
                    send(3'd4, 3'd2, 7'(s), BASE + 26'(4 * s), 4'hF, 32'h0, 1'b0);
                bp_done = 1'b1;
            end
        join_none
        repeat (10) @(negedge clock);
        check("bp_accepted", 64'(accepted), 64'd3);
        check("bp_a_ready", 64'(tl.a_ready), 64'd0);
        ready_mode = 1;
        w = 0;
        while (!bp_done && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("bp_accepted_after", 64'(accepted), 64'd5);
        @(posedge clock);
        #1;

        // Streaming throughput.
        repeat (5) @(posedge clock);
        #1;
        dfire_cyc.delete();
        for (int i = 0; i < 16; i++) begin
            send(3'd4, 3'd2, 7'(i), BASE + 26'(4 * i), 4'hF, 32'h0, 1'b0);
            if (i == 0) first_fire = fire_cyc;
        end
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            @(negedge clock);
            w++;
        end
        check("stream_beats", 64'(dfire_cyc.size()), 64'd16);
        if (dfire_cyc.size() == 16) begin
            check("stream_first", 64'(dfire_cyc[0]), 64'(first_fire + 2));
            check("stream_last", 64'(dfire_cyc[15]), 64'(dfire_cyc[0] + 15));
        end

        // Reset mid-stream.
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++)
            send(3'd4, 3'd2, 7'(i), BASE + 26'(4 * i), 4'hF, 32'h0, 1'b0);
        check("pre_reset_d_valid", 64'(tl.d_valid), 64'd1);
        #1;
        reset = 1'b0;
        #1;
        check("reset_mid_d_valid", 64'(tl.d_valid), 64'd0);
        check("reset_mid_a_ready", 64'(tl.a_ready), 64'd1);
        exp_q.delete();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        send(3'd4, 3'd2, 7'd33, BASE + 26'h10, 4'hF, 32'h0, 1'b0);

        // Randomized traffic under random d_ready.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: r_op = 3'd4;
                3, 4:    r_op = 3'd0;
                5, 6:    r_op = 3'd1;
                default: r_op = 3'($urandom_range(0, 7));
            endcase
            r_sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r_addr = BASE + 26'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 9) == 0)
                r_addr = ($urandom_range(0, 1) == 0) ? BASE - 26'($urandom_range(1, 256))
                                                     : BASE + 26'(DEPTH * 4) + 26'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && r_sz <= 3'd2)
                r_addr = r_addr & ~26'((1 << r_sz) - 1);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clock);
                #1;
            end
            send(r_op, r_sz, 7'($urandom_range(0, 127)), r_addr, 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 9) == 0));
        end
        ready_mode = 1;
        w = 0;
        while (exp_q.size() != 0 && w < 1000) begin
            @(negedge clock);
            w++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
